// File: rtl/vga_frame_update_arbiter_pkg.sv
// Shared constants and FSM encoding for the VGA frame-update arbiter.
// Holds the display geometry used to detect vertical blanking, the text-slot
// count that fixes the default slot address width, and the arbiter state type.
package vga_frame_update_arbiter_pkg;

  localparam int V_ACTIVE_DEF = 480;  // first scan line that is vertical blanking
  localparam int H_ACTIVE     = 640;
  localparam int TXT_SLOTS    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/vga_frame_update_arbiter_if.sv
// Requester / text-buffer bus of the frame-update arbiter.
//   req, req_addr, req_data : per-requester write requests (packed, requester i
//                             at [i*W +: W])
//   ack                     : one-hot, one-cycle grant/complete pulse
//   wr_en, wr_addr, wr_data : text-buffer write port toward the painter
// master = requester / buffer side, slave = arbiter side.
interface vga_frame_update_arbiter_if #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        ack;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;

  modport master (
    output req, req_addr, req_data,
    input  ack, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req, req_addr, req_data,
    output ack, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/vga_frame_update_arbiter_rr_arbiter.sv
// Combinational round-robin grant search.
//   req       : request vector
//   ptr       : index where the search starts (highest priority this round)
//   gnt_valid : at least one request present
//   gnt_idx   : first requesting index at or after ptr, wrapping
module rr_arbiter #(
  parameter int NREQ  = 3,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);
  int idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(idx);
      end
    end
  end
endmodule

// File: rtl/vga_frame_update_arbiter.sv
// Frame-update arbiter: shares the painter's text-slot buffer among NREQ
// requesters and commits writes only during vertical blanking so a frame never
// tears. Also latches the mouse position once per frame at vblank entry.
//   clk_100MHz, reset_n : clock, asynchronous active-low reset
//   pixel_y             : current scan line from the painter
//   xm_in, ym_in        : raw mouse coordinates
//   xm, ym              : frame-stable mouse coordinates
//   frame_cnt           : count of vblank entries (wraps)
//   bus                 : requester handshake and text-buffer write port
module vga_frame_update_arbiter
  import vga_frame_update_arbiter_pkg::*;
#(
  parameter int NREQ         = 3,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 8,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int MAX_WR_FRAME = 16
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic [9:0] pixel_y,
  input  logic [9:0] xm_in,
  input  logic [9:0] ym_in,
  output logic [9:0] xm,
  output logic [9:0] ym,
  output logic [7:0] frame_cnt,
  vga_frame_update_arbiter_if.slave bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state, state_next;
  logic              vblank, vblank_q, vblank_rise;
  logic [IDX_W-1:0]  ptr, g_q;
  logic [7:0]        budget;
  logic              gnt_valid;
  logic [IDX_W-1:0]  gnt_idx;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  assign vblank      = (int'(pixel_y) >= V_ACTIVE);
  assign vblank_rise = vblank & ~vblank_q;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
    .req       (bus.req),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // State register
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (vblank) state_next = ST_ARB;
      ST_ARB: begin
        if (!vblank)          state_next = ST_IDLE;
        else if (budget == 0) state_next = ST_DONE;
        else if (gnt_valid)   state_next = ST_WRITE;
      end
      // The write completes even if vblank ended this cycle.
      ST_WRITE: state_next = vblank ? ST_ARB : ST_IDLE;
      ST_DONE:  if (!vblank) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs: strobe and grant pulse are decoded straight from WRITE so that a
  // reset clears them immediately.
  always_comb begin
    bus.wr_en = 1'b0;
    bus.ack   = '0;
    if (state == ST_WRITE) begin
      bus.wr_en = 1'b1;
      bus.ack   = NREQ'(1) << g_q;
    end
  end

  assign bus.wr_addr = addr_q;
  assign bus.wr_data = data_q;

  // Datapath / bookkeeping registers
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      vblank_q  <= 1'b0;
      ptr       <= '0;
      g_q       <= '0;
      budget    <= 8'(MAX_WR_FRAME);
      addr_q    <= '0;
      data_q    <= '0;
      xm        <= '0;
      ym        <= '0;
      frame_cnt <= '0;
    end else begin
      vblank_q <= vblank;

      if (vblank_rise) begin
        xm        <= xm_in;
        ym        <= ym_in;
        frame_cnt <= frame_cnt + 8'd1;
      end

      // A new frame's refill wins over a decrement in the same cycle.
      if (vblank_rise)              budget <= 8'(MAX_WR_FRAME);
      else if (state == ST_WRITE)   budget <= budget - 8'd1;

      // Capture the winner's fields in ARB; they hold while wr_en is low.
      if (state == ST_ARB && state_next == ST_WRITE) begin
        g_q    <= gnt_idx;
        addr_q <= bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
        data_q <= bus.req_data[int'(gnt_idx)*DATA_W +: DATA_W];
      end

      if (state == ST_WRITE)
        ptr <= (int'(g_q) == NREQ-1) ? '0 : g_q + IDX_W'(1);
    end
  end
endmodule

// File: tb/tb_vga_frame_update_arbiter.sv
// Directed bench for vga_frame_update_arbiter (NREQ=3, ADDR_W=5, DATA_W=8).
module tb_vga_frame_update_arbiter;
  logic       clk_100MHz;
  logic       reset_n;
  logic [9:0] pixel_y, xm_in, ym_in;
  logic [9:0] xm, ym;
  logic [7:0] frame_cnt;
  int         checks = 0;
  int         errors = 0;

  vga_frame_update_arbiter_if #(.NREQ(3), .ADDR_W(5), .DATA_W(8)) bus_if ();

  vga_frame_update_arbiter #(
    .NREQ(3), .ADDR_W(5), .DATA_W(8), .V_ACTIVE(480), .MAX_WR_FRAME(16)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .pixel_y    (pixel_y),
    .xm_in      (xm_in),
    .ym_in      (ym_in),
    .xm         (xm),
    .ym         (ym),
    .frame_cnt  (frame_cnt),
    .bus        (bus_if)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    pixel_y = 10'd0;
    xm_in = 10'd0;
    ym_in = 10'd0;
    bus_if.req = 3'b000;
    bus_if.req_addr = '0;
    bus_if.req_data = '0;
    tick(2);
    chk("rst_wr_en", 32'(bus_if.wr_en), 0);
    chk("rst_ack", 32'(bus_if.ack), 0);
    chk("rst_wr_addr", 32'(bus_if.wr_addr), 0);
    chk("rst_wr_data", 32'(bus_if.wr_data), 0);
    chk("rst_xm", 32'(xm), 0);
    chk("rst_ym", 32'(ym), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    reset_n = 1'b1;
    tick();

    // Single request waits through active video, then is written in vblank.
    bus_if.req = 3'b001;
    bus_if.req_addr = {5'd0, 5'd0, 5'd5};
    bus_if.req_data = {8'h00, 8'h00, 8'h41};
    pixel_y = 10'd100;
    tick(3);
    chk("active_no_wr", 32'(bus_if.wr_en), 0);
    chk("active_no_ack", 32'(bus_if.ack), 0);
    pixel_y = 10'd480;
    tick();                                        // ARB
    chk("arb_no_wr", 32'(bus_if.wr_en), 0);
    chk("frame_cnt_1", 32'(frame_cnt), 1);
    tick();                                        // WRITE
    chk("single_wr_en", 32'(bus_if.wr_en), 1);
    chk("single_addr", 32'(bus_if.wr_addr), 5);
    chk("single_data", 32'(bus_if.wr_data), 32'h41);
    chk("single_ack", 32'(bus_if.ack), 32'b001);
    bus_if.req = 3'b000;
    tick();                                        // ARB
    chk("single_ack_gone", 32'(bus_if.ack), 0);
    chk("hold_addr", 32'(bus_if.wr_addr), 5);
    chk("hold_data", 32'(bus_if.wr_data), 32'h41);

    // Reset asserted in the middle of a write.
    bus_if.req = 3'b010;
    bus_if.req_addr = {5'd0, 5'd7, 5'd5};
    bus_if.req_data = {8'h00, 8'h33, 8'h41};
    tick();                                        // WRITE
    chk("pre_rst_ack", 32'(bus_if.ack), 32'b010);
    reset_n = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(bus_if.wr_en), 0);
    chk("midrst_ack", 32'(bus_if.ack), 0);
    chk("midrst_addr", 32'(bus_if.wr_addr), 0);
    chk("midrst_data", 32'(bus_if.wr_data), 0);
    chk("midrst_frame", 32'(frame_cnt), 0);
    bus_if.req = 3'b000;
    pixel_y = 10'd100;
    tick();
    reset_n = 1'b1;
    tick();

    // Fairness with all three requesting, budget of 16 after reset.
    bus_if.req = 3'b111;
    bus_if.req_addr = {5'd3, 5'd2, 5'd1};
    bus_if.req_data = {8'h30, 8'h20, 8'h10};
    tick();
    pixel_y = 10'd480;
    tick();                                        // ARB
    for (int n = 0; n < 16; n++) begin
      tick();                                      // WRITE
      chk("fair_ack", 32'(bus_if.ack), 32'(1 << (n % 3)));
      chk("fair_addr", 32'(bus_if.wr_addr), 32'((n % 3) + 1));
      tick();                                      // ARB
      chk("fair_gap", 32'(bus_if.ack), 0);
    end
    tick();                                        // DONE
    chk("budget_done", 32'(bus_if.wr_en), 0);
    tick(3);
    chk("budget_done_hold", 32'(bus_if.wr_en), 0);
    pixel_y = 10'd100;
    tick();                                        // IDLE
    pixel_y = 10'd480;
    tick();                                        // ARB, budget refilled
    tick();                                        // WRITE, ptr resumes at 1
    chk("next_frame_ack", 32'(bus_if.ack), 32'b010);
    bus_if.req = 3'b000;
    tick();

    // Mouse latch at vblank entry only.
    pixel_y = 10'd479;
    xm_in = 10'd300;
    ym_in = 10'd200;
    tick();
    chk("mouse_before", 32'(xm), 0);
    pixel_y = 10'd480;
    tick();
    chk("mouse_xm", 32'(xm), 300);
    chk("mouse_ym", 32'(ym), 200);
    xm_in = 10'd50;
    tick();
    chk("mouse_vblank_hold", 32'(xm), 300);
    pixel_y = 10'd10;
    xm_in = 10'd77;
    tick();
    chk("mouse_active_hold", 32'(xm), 300);
    pixel_y = 10'd480;
    tick();
    chk("mouse_next_frame", 32'(xm), 77);

    // Frame counter wrap after 256 vblank entries.
    reset_n = 1'b0;
    pixel_y = 10'd100;
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) begin
      pixel_y = 10'd480;
      tick();
      pixel_y = 10'd100;
      tick();
      if (i == 254) chk("frame_cnt_255", 32'(frame_cnt), 255);
    end
    chk("frame_cnt_wrap", 32'(frame_cnt), 0);

    // vblank ends abruptly while in ARB; pending request waits a frame.
    pixel_y = 10'd520;
    tick();                                        // ARB
    bus_if.req = 3'b100;
    bus_if.req_addr = {5'd9, 5'd0, 5'd0};
    bus_if.req_data = {8'h55, 8'h00, 8'h00};
    pixel_y = 10'd0;
    tick();                                        // IDLE
    chk("jump_no_wr", 32'(bus_if.wr_en), 0);
    tick(2);
    chk("jump_wait", 32'(bus_if.wr_en), 0);
    pixel_y = 10'd480;
    tick();                                        // ARB
    tick();                                        // WRITE
    chk("jump_served_ack", 32'(bus_if.ack), 32'b100);
    chk("jump_served_addr", 32'(bus_if.wr_addr), 9);
    chk("jump_served_data", 32'(bus_if.wr_data), 32'h55);
    bus_if.req = 3'b000;
    tick();                                        // ARB

    // Write in flight when vblank drops still completes.
    bus_if.req = 3'b001;
    bus_if.req_addr = {5'd9, 5'd0, 5'd4};
    bus_if.req_data = {8'h55, 8'h00, 8'h66};
    tick();                                        // WRITE
    pixel_y = 10'd0;
    chk("edge_wr_en", 32'(bus_if.wr_en), 1);
    chk("edge_ack", 32'(bus_if.ack), 32'b001);
    chk("edge_addr", 32'(bus_if.wr_addr), 4);
    tick();                                        // IDLE
    chk("edge_idle", 32'(bus_if.wr_en), 0);
    tick(2);
    chk("edge_idle_hold", 32'(bus_if.wr_en), 0);
    pixel_y = 10'd480;
    tick();                                        // ARB
    tick();                                        // WRITE
    chk("edge_next_ack", 32'(bus_if.ack), 32'b001);
    bus_if.req = 3'b000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
